// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS-subset control FSM
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback, and drives every datapath enable including ALUSrcB.
// Ports:
//   CLK, RST_n            clock, asynchronous active-low reset
//   Op, Funct             instruction fields (stable from ID to end of instr)
//   mem_ready             memory completed the current read/write this cycle
//   PCWrite..PCSource     datapath control (combinational from state)
//   state                 current state, debug
//   halted, illegal_op    HALT indication; illegal_op sticky until reset
module mc_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [2:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic               illegal_op
);

    typedef enum logic [STATE_W-1:0] {
        S_RST    = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_EX_R   = 4'd3,
        S_EX_I   = 4'd4,
        S_EX_MA  = 4'd5,
        S_EX_BR  = 4'd6,
        S_EX_J   = 4'd7,
        S_MEM_RD = 4'd8,
        S_MEM_WR = 4'd9,
        S_WB_ALU = 4'd10,
        S_WB_MEM = 4'd11,
        S_HALT   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] SRCB_REGB  = 3'b000;
    localparam logic [2:0] SRCB_FOUR  = 3'b001;
    localparam logic [2:0] SRCB_LSADR = 3'b010;
    localparam logic [2:0] SRCB_BEQ   = 3'b011;
    localparam logic [2:0] SRCB_ZEXT  = 3'b100;
    localparam logic [2:0] SRCB_ZERO  = 3'b101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   funct_legal;

    always_comb begin
        funct_legal = 1'b0;
        case (Funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default: funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;

        case (state_q)
            S_RST: begin
                ALUSrcB = SRCB_ZERO;
                state_d = S_IF;
            end
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // PC+4 and IR load happen on the same edge the fetch completes.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                // Branch target computed speculatively into ALUOut.
                ALUSrcB = SRCB_BEQ;
                case (Op)
                    OP_RTYPE:       state_d = S_EX_R;
                    OP_ADDI, OP_ORI: state_d = S_EX_I;
                    OP_LW, OP_SW:   state_d = S_EX_MA;
                    OP_BEQ:         state_d = S_EX_BR;
                    OP_J:           state_d = S_EX_J;
                    OP_HALT:        state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EX_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REGB;
                ALUOp   = ALU_FUNCT;
                if (funct_legal) begin
                    state_d = S_WB_ALU;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EX_I: begin
                ALUSrcA = 1'b1;
                if (Op == OP_ORI) begin
                    ALUSrcB = SRCB_ZEXT;
                    ALUOp   = ALU_OR;
                end else begin
                    ALUSrcB = SRCB_LSADR;
                    ALUOp   = ALU_ADD;
                end
                state_d = S_WB_ALU;
            end
            S_EX_MA: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_LSADR;
                state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_EX_BR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REGB;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_IF;
            end
            S_EX_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_IF;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = S_IF;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = (Op == OP_RTYPE);
                state_d  = S_IF;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_IF;
            end
            S_HALT: begin
                ALUSrcB = SRCB_ZERO;
            end
            default: begin
                // Unused encodings park safely in HALT.
                ALUSrcB = SRCB_ZERO;
                state_d = S_HALT;
            end
        endcase
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic       CLK;
    logic       RST_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [2:0] ALUSrcB, ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       halted, illegal_op;

    int n_chk  = 0;
    int n_fail = 0;

    mc_ctrl_fsm #(.STATE_W(4)) dut (
        .CLK(CLK), .RST_n(RST_n), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .halted(halted),
        .illegal_op(illegal_op)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Holds reset over two negedges, releases it at a negedge; FSM is in RST afterwards.
    task automatic do_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        #1;
    endtask

    // Advance to the next negedge, drive mem_ready, settle.
    task automatic cyc(input logic rdy);
        @(negedge CLK);
        mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_chk++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %0b want 0", illegal_op); end
        n_chk++; if (ALUSrcB !== 3'b101 || ALUOp !== 3'b000) begin n_fail++; $display("FAIL reset_alu: got B=%0b op=%0b want 101/000", ALUSrcB, ALUOp); end
        n_chk++;
        if ({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, halted} !== 7'b0) begin
            n_fail++; $display("FAIL reset_enables: got %b want 0000000",
                {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, halted});
        end
        repeat (2) @(negedge CLK);
        #1;
        n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_hold: got %0d want 0", state); end
        RST_n = 1'b1;
    endtask

    task automatic test_rtype();
        do_reset();
        Op = 6'b000000; Funct = 6'b100000;
        n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL rtype_s0: got %0d want 0", state); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL rtype_s1: got %0d want 1", state); end
        n_chk++; if ({MemRead, IRWrite, PCWrite, IorD} !== 4'b1110 || ALUSrcB !== 3'b001) begin
            n_fail++; $display("FAIL rtype_if: got rd/ir/pc/iord=%b B=%0b want 1110/001", {MemRead, IRWrite, PCWrite, IorD}, ALUSrcB); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd2 || ALUSrcB !== 3'b011) begin n_fail++; $display("FAIL rtype_id: got s=%0d B=%0b want 2/011", state, ALUSrcB); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd3 || ALUSrcB !== 3'b000 || ALUOp !== 3'b010 || ALUSrcA !== 1'b1) begin
            n_fail++; $display("FAIL rtype_ex: got s=%0d B=%0b op=%0b A=%0b want 3/000/010/1", state, ALUSrcB, ALUOp, ALUSrcA); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd10 || RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
            n_fail++; $display("FAIL rtype_wb: got s=%0d rw=%0b rd=%0b m2r=%0b want 10/1/1/0", state, RegWrite, RegDst, MemtoReg); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL rtype_next: got %0d want 1", state); end
    endtask

    task automatic test_lw_wait();
        int cnt;
        do_reset();
        Op = 6'b100011; Funct = 6'b000000;
        cyc(1'b0);
        n_chk++; if (state !== 4'd1 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
            n_fail++; $display("FAIL lw_if_wait: got s=%0d ir=%0b pc=%0b want 1/0/0", state, IRWrite, PCWrite); end
        cyc(1'b1);   // IF completes
        cyc(1'b0);   // ID, mem_ready ignored
        cyc(1'b0);   // EX_MA
        n_chk++; if (state !== 4'd5 || ALUSrcB !== 3'b010 || ALUOp !== 3'b000) begin
            n_fail++; $display("FAIL lw_exma: got s=%0d B=%0b op=%0b want 5/010/000", state, ALUSrcB, ALUOp); end
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(i == 2);
            if (state == 4'd8 && MemRead === 1'b1 && IorD === 1'b1) cnt++;
        end
        n_chk++; if (cnt != 3) begin n_fail++; $display("FAIL lw_memrd_hold: got %0d cycles want 3", cnt); end
        cyc(1'b0);
        n_chk++; if (state !== 4'd11 || MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
            n_fail++; $display("FAIL lw_wbmem: got s=%0d m2r=%0b rw=%0b rd=%0b want 11/1/1/0", state, MemtoReg, RegWrite, RegDst); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL lw_next: got %0d want 1", state); end
    endtask

    task automatic test_ori_addi();
        do_reset();
        Op = 6'b001101; Funct = 6'b111111;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        n_chk++; if (state !== 4'd4 || ALUSrcB !== 3'b100 || ALUOp !== 3'b011 || ALUSrcA !== 1'b1) begin
            n_fail++; $display("FAIL ori_ex: got s=%0d B=%0b op=%0b A=%0b want 4/100/011/1", state, ALUSrcB, ALUOp, ALUSrcA); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd10 || RegDst !== 1'b0 || RegWrite !== 1'b1) begin
            n_fail++; $display("FAIL ori_wb: got s=%0d rd=%0b rw=%0b want 10/0/1", state, RegDst, RegWrite); end
        Op = 6'b001000;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        n_chk++; if (state !== 4'd4 || ALUSrcB !== 3'b010 || ALUOp !== 3'b000) begin
            n_fail++; $display("FAIL addi_ex: got s=%0d B=%0b op=%0b want 4/010/000", state, ALUSrcB, ALUOp); end
    endtask

    task automatic test_beq_j();
        do_reset();
        Op = 6'b000100;
        cyc(1'b1); cyc(1'b1);
        n_chk++; if (state !== 4'd2 || ALUSrcB !== 3'b011 || ALUSrcA !== 1'b0) begin
            n_fail++; $display("FAIL beq_id: got s=%0d B=%0b A=%0b want 2/011/0", state, ALUSrcB, ALUSrcA); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd6 || ALUSrcB !== 3'b000 || ALUOp !== 3'b001 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 || PCWrite !== 1'b0) begin
            n_fail++; $display("FAIL beq_ex: got s=%0d B=%0b op=%0b pwc=%0b src=%0b pw=%0b want 6/000/001/1/01/0",
                state, ALUSrcB, ALUOp, PCWriteCond, PCSource, PCWrite); end
        Op = 6'b000010;
        cyc(1'b1);
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL beq_next: got %0d want 1", state); end
        cyc(1'b1); cyc(1'b1);
        n_chk++; if (state !== 4'd7 || PCWrite !== 1'b1 || PCSource !== 2'b10) begin
            n_fail++; $display("FAIL j_ex: got s=%0d pw=%0b src=%0b want 7/1/10", state, PCWrite, PCSource); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL j_next: got %0d want 1", state); end
    endtask

    task automatic test_illegal();
        int bad;
        do_reset();
        Op = 6'b010101;
        cyc(1'b1); cyc(1'b1);
        n_chk++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_before: got %0b want 0", illegal_op); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd15 || halted !== 1'b1 || illegal_op !== 1'b1 || ALUSrcB !== 3'b101) begin
            n_fail++; $display("FAIL ill_halt: got s=%0d h=%0b ill=%0b B=%0b want 15/1/1/101", state, halted, illegal_op, ALUSrcB); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            Op = 6'($urandom);
            cyc(1'($urandom));
            if (state !== 4'd15 || halted !== 1'b1 || illegal_op !== 1'b1 || MemRead !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL ill_absorb: got %0d bad cycles want 0", bad); end
        // Deliberate HALT opcode: halted but not illegal.
        do_reset();
        n_chk++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_cleared: got %0b want 0", illegal_op); end
        Op = 6'b111111;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        n_chk++; if (state !== 4'd15 || illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL halt_op: got s=%0d ill=%0b want 15/0", state, illegal_op); end
        // Illegal Funct on R-type.
        do_reset();
        Op = 6'b000000; Funct = 6'b100001;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        n_chk++; if (state !== 4'd3 || illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL funct_ex: got s=%0d ill=%0b want 3/0", state, illegal_op); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd15 || illegal_op !== 1'b1) begin
            n_fail++; $display("FAIL funct_halt: got s=%0d ill=%0b want 15/1", state, illegal_op); end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        Op = 6'b101011;
        cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
        n_chk++; if (state !== 4'd9 || MemWrite !== 1'b1 || IorD !== 1'b1) begin
            n_fail++; $display("FAIL sw_memwr: got s=%0d mw=%0b iord=%0b want 9/1/1", state, MemWrite, IorD); end
        #2;          // still before the next rising edge
        RST_n = 1'b0;
        #1;
        n_chk++; if (state !== 4'd0 || MemWrite !== 1'b0 || IorD !== 1'b0) begin
            n_fail++; $display("FAIL sw_async_rst: got s=%0d mw=%0b iord=%0b want 0/0/0", state, MemWrite, IorD); end
        @(negedge CLK);
        RST_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL sw_release: got %0d want 0", state); end
        cyc(1'b1);
        n_chk++; if (state !== 4'd1 || MemWrite !== 1'b0 || MemRead !== 1'b1) begin
            n_fail++; $display("FAIL sw_refetch: got s=%0d mw=%0b mr=%0b want 1/0/1", state, MemWrite, MemRead); end
    endtask

    // Random legal instructions with random memory stalls. The model predicts
    // only instruction length and how many cycles each enable is asserted.
    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        int cls, wi, wm, len, ms;
        int c_mr, c_mw, c_ir, c_pw, c_pwc, c_rw, c_zext;
        int e_mr, e_mw, e_pw, e_rw;
        ops = '{6'b000000, 6'b001000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        do_reset();
        for (int n = 0; n < 40; n++) begin
            cls = int'($urandom_range(0, 6));
            wi  = int'($urandom_range(0, 3));
            wm  = (cls == 3 || cls == 4) ? int'($urandom_range(0, 3)) : 0;
            case (cls)
                0, 1, 2, 4: len = 4;
                3:          len = 5;
                default:    len = 3;
            endcase
            len = len + wi + wm;
            ms  = wi + 3;
            c_mr = 0; c_mw = 0; c_ir = 0; c_pw = 0; c_pwc = 0; c_rw = 0; c_zext = 0;
            for (int k = 0; k < len; k++) begin
                @(negedge CLK);
                if (k == 0) begin
                    Op = ops[cls];
                    Funct = fns[$urandom_range(0, 4)];
                end
                if (k < wi) mem_ready = 1'b0;
                else if (k == wi) mem_ready = 1'b1;
                else if ((cls == 3 || cls == 4) && k >= ms && k < ms + wm) mem_ready = 1'b0;
                else if ((cls == 3 || cls == 4) && k == ms + wm) mem_ready = 1'b1;
                else mem_ready = 1'($urandom);
                #1;
                if (k == 0) begin
                    n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL rnd_start[%0d]: got s=%0d want 1", n, state); end
                end
                c_mr   += int'(MemRead);
                c_mw   += int'(MemWrite);
                c_ir   += int'(IRWrite);
                c_pw   += int'(PCWrite);
                c_pwc  += int'(PCWriteCond);
                c_rw   += int'(RegWrite);
                c_zext += int'(ALUSrcB == 3'b100);
            end
            e_mr = wi + 1 + ((cls == 3) ? wm + 1 : 0);
            e_mw = (cls == 4) ? wm + 1 : 0;
            e_pw = 1 + ((cls == 6) ? 1 : 0);
            e_rw = (cls <= 3) ? 1 : 0;
            n_chk++;
            if (c_mr != e_mr || c_mw != e_mw || c_ir != 1 || c_pw != e_pw ||
                c_pwc != ((cls == 5) ? 1 : 0) || c_rw != e_rw || c_zext != ((cls == 2) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rnd_counts[%0d] op=%b wi=%0d wm=%0d: got mr=%0d mw=%0d ir=%0d pw=%0d pwc=%0d rw=%0d zx=%0d want mr=%0d mw=%0d ir=1 pw=%0d pwc=%0d rw=%0d zx=%0d",
                    n, ops[cls], wi, wm, c_mr, c_mw, c_ir, c_pw, c_pwc, c_rw, c_zext,
                    e_mr, e_mw, e_pw, (cls == 5) ? 1 : 0, e_rw, (cls == 2) ? 1 : 0);
            end
        end
        @(negedge CLK);
        mem_ready = 1'b0;
        #1;
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL rnd_end: got s=%0d want 1", state); end
    endtask

    initial begin
        RST_n = 1'b0;
        Op = 6'b0;
        Funct = 6'b0;
        mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_ori_addi();
        test_beq_j();
        test_illegal();
        test_reset_mid_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
